// File: rtl/fpaddsub_pkg.sv
// Shared widths and stage-1 payload for the FP add/sub alignment pipeline.
package fpaddsub_pkg;
   localparam int MANT_W  = 33;
   localparam int EXP_W   = 8;
   localparam int FRAC_W  = 23;
   localparam int GUARD_W = 9;
   localparam int SHAMT_W = 6;

   typedef struct packed {
      logic               swap;
      logic [EXP_W-1:0]   emax;
      logic               sign_max;
      logic               sign_min;
      logic [MANT_W-1:0]  mmax;
      logic [MANT_W-1:0]  mmin;
      logic [SHAMT_W-1:0] diff;
   } align_s1_t;
endpackage

// File: rtl/fpaddsub_align_shifter.sv
// 33-bit logarithmic right shifter; every level folds dropped bits into bit 0.
module fpaddsub_align_shifter
   import fpaddsub_pkg::*;
(
   input  logic [MANT_W-1:0]  din,
   input  logic [SHAMT_W-1:0] amt,
   output logic [MANT_W-1:0]  dout
);
   logic [MANT_W-1:0] l5, l4, l3, l2, l1;

   assign l5 = amt[5] ? {32'b0, din[32] | (|din[31:0])} : din;
   assign l4 = amt[4] ? {16'b0, l5[32:17], l5[16] | (|l5[15:0])} : l5;
   assign l3 = amt[3] ? {8'b0, l4[32:9], l4[8] | (|l4[7:0])} : l4;
   assign l2 = amt[2] ? {4'b0, l3[32:5], l3[4] | (|l3[3:0])} : l3;
   assign l1 = amt[1] ? {2'b0, l2[32:3], l2[2] | (|l2[1:0])} : l2;
   assign dout = amt[0] ? {1'b0, l1[32:2], l1[1] | l1[0]} : l1;
endmodule

// File: rtl/fpaddsub_align_pipe.sv
// Two-stage pre-add alignment: magnitude ordering, then sticky right shift.
// Define FPADDSUB_ALIGN_DENORM_EN for gradual-underflow alignment of exp=0 inputs.
module fpaddsub_align_pipe
   import fpaddsub_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_a,
   input  logic [31:0]       in_b,
   input  logic              in_op,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [MANT_W-1:0] out_mmax,
   output logic [MANT_W-1:0] out_mmin,
   output logic [EXP_W-1:0]  out_emax,
   output logic              out_sign_max,
   output logic              out_sign_min,
   output logic              out_swap,
   output logic              out_eff_sub
);
   logic [EXP_W-1:0]  ea, eb, xa, xb, diff;
   logic [FRAC_W-1:0] fa, fb;
   logic [MANT_W-1:0] ma, mb, shifted;
   logic              sb_eff, swap;
   logic              s1_valid, s1_adv, s2_adv;
   align_s1_t         s1_d, s1_q;

   assign ea     = in_a[30:23];
   assign eb     = in_b[30:23];
   assign fa     = in_a[22:0];
   assign fb     = in_b[22:0];
   assign sb_eff = in_b[31] ^ in_op;
   assign swap   = {eb, fb} > {ea, fa};

`ifdef FPADDSUB_ALIGN_DENORM_EN
   // Denormals align as if their exponent were 1
   assign ma = {|ea, fa, {GUARD_W{1'b0}}};
   assign mb = {|eb, fb, {GUARD_W{1'b0}}};
   assign xa = (ea == '0) ? 8'd1 : ea;
   assign xb = (eb == '0) ? 8'd1 : eb;
`else
   assign ma = (ea == '0) ? '0 : {1'b1, fa, {GUARD_W{1'b0}}};
   assign mb = (eb == '0) ? '0 : {1'b1, fb, {GUARD_W{1'b0}}};
   assign xa = ea;
   assign xb = eb;
`endif

   assign diff = swap ? xb - xa : xa - xb;

   always_comb begin
      s1_d          = '0;
      s1_d.swap     = swap;
      s1_d.emax     = swap ? eb : ea;
      s1_d.sign_max = swap ? sb_eff : in_a[31];
      s1_d.sign_min = swap ? in_a[31] : sb_eff;
      s1_d.mmax     = swap ? mb : ma;
      s1_d.mmin     = swap ? ma : mb;
      s1_d.diff     = (diff > 8'd63) ? 6'd63 : diff[5:0];
   end

   assign s2_adv   = !out_valid | out_ready;
   assign s1_adv   = !s1_valid | s2_adv;
   assign in_ready = s1_adv;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_q     <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) s1_q <= s1_d;
      end
   end

   fpaddsub_align_shifter u_shift (
      .din  (s1_q.mmin),
      .amt  (s1_q.diff),
      .dout (shifted)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_mmax     <= '0;
         out_mmin     <= '0;
         out_emax     <= '0;
         out_sign_max <= 1'b0;
         out_sign_min <= 1'b0;
         out_swap     <= 1'b0;
         out_eff_sub  <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_mmax     <= s1_q.mmax;
            out_mmin     <= shifted;
            out_emax     <= s1_q.emax;
            out_sign_max <= s1_q.sign_max;
            out_sign_min <= s1_q.sign_min;
            out_swap     <= s1_q.swap;
            out_eff_sub  <= s1_q.sign_max ^ s1_q.sign_min;
         end
      end
   end
endmodule

// File: tb/tb_fpaddsub_align_pipe.sv
// Scoreboard bench for the alignment pipeline: directed vectors, stalls, reset.
module tb_fpaddsub_align_pipe;
   typedef struct packed {
      logic [32:0] mmax;
      logic [32:0] mmin;
      logic [7:0]  emax;
      logic        smax;
      logic        smin;
      logic        swap;
      logic        eff;
   } exp_t;

   logic        clk, rst_n;
   logic        in_valid, in_ready, in_op;
   logic [31:0] in_a, in_b;
   logic        out_valid, out_ready;
   logic [32:0] out_mmax, out_mmin;
   logic [7:0]  out_emax;
   logic        out_sign_max, out_sign_min, out_swap, out_eff_sub;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   fpaddsub_align_pipe dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_op        (in_op),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_mmax     (out_mmax),
      .out_mmin     (out_mmin),
      .out_emax     (out_emax),
      .out_sign_max (out_sign_max),
      .out_sign_min (out_sign_min),
      .out_swap     (out_swap),
      .out_eff_sub  (out_eff_sub)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endfunction

   function automatic exp_t mk(logic [32:0] mx, logic [32:0] mn, logic [7:0] e,
                               logic sx, logic sn, logic sw);
      exp_t r;
      r.mmax = mx; r.mmin = mn; r.emax = e;
      r.smax = sx; r.smin = sn; r.swap = sw; r.eff = sx ^ sn;
      return r;
   endfunction

   // Monitor: pop and compare on every transfer
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output: got mmax %h expected none", out_mmax);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("mmax", 64'(out_mmax), 64'(e.mmax));
            chk("mmin", 64'(out_mmin), 64'(e.mmin));
            chk("emax", 64'(out_emax), 64'(e.emax));
            chk("flags", 64'({out_sign_max, out_sign_min, out_swap, out_eff_sub}),
                64'({e.smax, e.smin, e.swap, e.eff}));
         end
      end
   end

   // Outputs must hold while stalled
   logic        held;
   logic [79:0] snap;
   always @(negedge clk) begin
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         if (held)
            chk("stall_hold", 64'(snap ^ {out_mmax, out_mmin, out_emax, out_sign_max,
                out_sign_min, out_swap, out_eff_sub}), 64'd0);
         held = out_valid && !out_ready;
         snap = {out_mmax, out_mmin, out_emax, out_sign_max, out_sign_min,
                 out_swap, out_eff_sub};
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b,
                       input logic op, input exp_t e);
      int n;
      n = 0;
      in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) begin
            sb.push_back(e);
            @(posedge clk);
            #1;
            break;
         end
         n++;
         if (n > 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready 0 expected 1");
            break;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic latency_check(input string nm);
      chk({nm, "_lat1"}, 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk({nm, "_lat2"}, 64'(out_valid), 64'd1);
   endtask

   exp_t dn;

   initial begin
      rst_n = 0; in_valid = 0; in_a = 0; in_b = 0; in_op = 0; out_ready = 1;
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_fields", 64'(|{out_mmax, out_mmin, out_emax, out_sign_max,
          out_sign_min, out_swap, out_eff_sub}), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      @(posedge clk);
      #1;

      send(32'h3F800000, 32'h3F800000, 0,
           mk(33'h100000000, 33'h100000000, 8'h7F, 0, 0, 0));
      latency_check("equal");
      send(32'h3F800000, 32'h33800000, 0,
           mk(33'h100000000, 33'h000000100, 8'h7F, 0, 0, 0));
      send(32'h3F800000, 32'h2B800000, 0,
           mk(33'h100000000, 33'h000000001, 8'h7F, 0, 0, 0));
      send(32'h3F800000, 32'h40000000, 1,
           mk(33'h100000000, 33'h080000000, 8'h80, 1, 0, 1));
      send(32'h3F800000, 32'h3F800001, 0,
           mk(33'h100000200, 33'h100000000, 8'h7F, 0, 0, 1));
      send(32'h4B000000, 32'h3F800001, 0,
           mk(33'h100000000, 33'h000000201, 8'h96, 0, 0, 0));
`ifdef FPADDSUB_ALIGN_DENORM_EN
      dn = mk(33'h080000000, 33'h0, 8'h00, 0, 0, 0);
`else
      dn = mk(33'h0, 33'h0, 8'h00, 0, 0, 0);
`endif
      send(32'h00400000, 32'h00000000, 0, dn);
      repeat (4) @(posedge clk);
      #1;

      // Backpressure: two accepts fill the pipe, third waits
      out_ready = 0;
      send(32'h40400000, 32'h3F800000, 0,
           mk(33'h180000000, 33'h080000000, 8'h80, 0, 0, 0));
      send(32'h3F800000, 32'hC0000000, 0,
           mk(33'h100000000, 33'h080000000, 8'h80, 1, 0, 1));
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      fork
         send(32'hBF800000, 32'hBF800000, 1,
              mk(33'h100000000, 33'h100000000, 8'h7F, 1, 0, 0));
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      chk("bp_drained", 64'(sb.size()), 64'd0);

      // Reset with both stages full
      out_ready = 0;
      send(32'h40400000, 32'h3F800000, 0,
           mk(33'h180000000, 33'h080000000, 8'h80, 0, 0, 0));
      send(32'h3F800000, 32'h33800000, 0,
           mk(33'h100000000, 33'h000000100, 8'h7F, 0, 0, 0));
      chk("full_out_valid", 64'(out_valid), 64'd1);
      #2 rst_n = 0;
      #1;
      chk("midrst_out_valid", 64'(out_valid), 64'd0);
      chk("midrst_in_ready", 64'(in_ready), 64'd1);
      sb.delete();
      @(negedge clk);
      rst_n = 1;
      out_ready = 1;
      repeat (5) @(posedge clk);
      #1;
      chk("post_rst_idle", 64'(out_valid), 64'd0);
      send(32'h3F800000, 32'h40000000, 1,
           mk(33'h100000000, 33'h080000000, 8'h80, 1, 0, 1));
      latency_check("post_rst");

      for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
      repeat (2) @(posedge clk);
      chk("final_drain", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/fpaddsub_align_pipe.md
# fpaddsub_align_pipe

Pre-add alignment stage of the FP add/sub datapath: the right-shifting counterpart of the post-add normalizer. Accepts two IEEE-754 single-precision operands and an add/sub opcode, orders them by magnitude, and right-shifts the smaller mantissa by the exponent difference with sticky collection. Produces 33-bit aligned mantissas in the same hidden-bit-plus-extension format the normalizer consumes. Two-stage pipeline with valid/ready handshake on both sides.

## Interface
- No parameters; widths are fixed in the shared package.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  stage can accept the operand pair this cycle.
- in_a  in  32  operand A, IEEE-754 single.
- in_b  in  32  operand B, IEEE-754 single.
- in_op  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts the result this cycle.
- out_mmax  out  33  larger mantissa: [32] hidden, [31:9] fraction, [8:0] zero.
- out_mmin  out  33  smaller mantissa after right shift; [0] is sticky.
- out_emax  out  8  exponent of the larger operand.
- out_sign_max  out  1  sign of the larger operand.
- out_sign_min  out  1  effective sign of the smaller operand, after applying in_op.
- out_swap  out  1  1 when B was the larger operand.
- out_eff_sub  out  1  out_sign_max XOR out_sign_min.

## Operation
- Effective B sign = in_b[31] ^ in_op.
- Magnitude compare on {exp, frac}. Swap when B is strictly larger; on ties, A is max and out_swap = 0.
- Hidden bit = 1 for exp ≠ 0. Denormal handling is described under Configuration.
- diff = emax − emin, 8-bit unsigned; never negative after the swap.
- Shift of mmin: the shifted-out bits are ORed into bit [0] together with the existing bit [0].
- diff ≥ 33: mmin = {32'b0, (pre-shift mmin ≠ 0)}.
- NaN and Inf are passed through unaltered. Exceptions are handled downstream; this block does no special-case logic.
- Stage 1 registers: swap decision, emax, signs, both 33-bit mantissas, diff saturated to 6 bits (63).
- Stage 2 registers: shifter output plus the pass-through fields.

## Timing
- Latency: exactly 2 cycles from the accepting edge (in_valid & in_ready) to out_valid high.
- Throughput: 1 result per cycle while out_ready = 1.
- Stall rules:
  - s2 advances when !s2_valid | out_ready.
  - s1 advances when !s1_valid | s2 advances.
  - in_ready = s1 advance condition; it is combinational from out_ready.
- While out_valid & !out_ready, every out_* field is held stable.
- Results are delivered in order. No data is dropped or duplicated under any backpressure pattern.
- Reset values: all out_* = 0, in_ready = 1 (both stages empty), internal valids = 0.
- Reset asserted mid-operation discards in-flight data. The first accepted input after release appears 2 cycles later.
- in_valid low leaves stages unchanged except for draining.

## Configuration
- FPADDSUB_ALIGN_DENORM_EN defined: exp = 0 operands get hidden bit 0 and effective exponent 1, giving gradual-underflow alignment.
- FPADDSUB_ALIGN_DENORM_EN undefined: exp = 0 operands are flushed to zero. The mantissa is forced to 0, sign is kept, and the exponent is treated as 0.

## Structure
- Shared package fpaddsub_pkg holds:
  - constants MANT_W = 33, EXP_W = 8, FRAC_W = 23, GUARD_W = 9
  - a packed struct for the stage-1 payload.
- Sub-module fpaddsub_align_shifter: combinational 33-bit right shift by 6-bit amount, with sticky OR. Implemented as 32/16/8/4/2/1 shift levels, each folding its dropped bits into the sticky bit.

## Test plan
- A = B = 0x3F800000, op = 0: out_mmax = out_mmin = 0x100000000, out_emax = 0x7F, out_swap = 0, out_eff_sub = 0, out_valid exactly 2 cycles after accept.
- A = 0x3F800000, B = 0x33800000 (diff 24): out_mmin = 0x000000100, sticky = 0. With B = 0x2B800000 (diff 40): out_mmin = 0x000000001.
- A = 0x3F800000, B = 0x40000000, op = 1: out_swap = 1, out_emax = 0x80, out_sign_max = 1, out_sign_min = 0, out_eff_sub = 1.
- Hold out_ready = 0 for 4 cycles while in_valid = 1 with 3 distinct pairs: in_ready drops after 2 accepts, outputs stay frozen, and all 3 results emerge in order once out_ready = 1.
- A = 0x00400000, B = 0x00000000: with FPADDSUB_ALIGN_DENORM_EN, out_mmax = 0x080000000 and out_emax = 0x00. Without it, out_mmax = 0.
- Assert rst_n = 0 with both stages full: out_valid = 0 and in_ready = 1 immediately; no stale result appears after release.
